// File: rtl/perf_counter_bank.sv
// ============================================================================
// Module   : perf_counter_bank
// Purpose  : Bank of independent start/done cycle counters, 1-cycle read port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SAT    = 1,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] done,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic              rd_err,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] finished
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_all;
  logic [NUM_CH-1:0]            ovf_all;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic             inc;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      inc       = 1'b0;
      case (state)
        IDLE: begin
          if (start[i] && !done[i]) begin
            inc       = 1'b1;
            state_nxt = RUN;
          end else if (start[i] && done[i]) begin
            state_nxt = HOLD;
          end
        end
        RUN: begin
          // done wins over start: the completing edge is not counted
          if (done[i]) begin
            state_nxt = HOLD;
          end else if (start[i]) begin
            inc = 1'b1;
          end
        end
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
      if (inc) begin
        if (&cnt) begin
          ovf_nxt = 1'b1;
          cnt_nxt = (SAT != 0) ? cnt : '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn || clear) begin
        state <= IDLE;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        ovf   <= ovf_nxt;
      end
    end

    assign cnt_all[i]  = cnt;
    assign ovf_all[i]  = ovf;
    assign busy[i]     = (state == RUN);
    assign finished[i] = (state == HOLD);
  end

  logic [CNT_W-1:0] sel_cnt;
  logic             sel_ovf;
  logic             sel_err;

  // Out-of-range selects match no channel, so the mux naturally yields zero
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_cnt = cnt_all[i];
        sel_ovf = ovf_all[i];
      end
    end
    sel_err = ({1'b0, rd_sel} >= (SEL_W + 1)'(NUM_CH));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= sel_cnt;
        rd_ovf  <= sel_ovf;
        rd_err  <= sel_err;
      end
    end
  end

endmodule

`default_nettype wire
